// File: rtl/rtc_write_seq.sv
// Burst write sequencer for the RTC register bus: buffers up to MAX_BURST words, writes them to
// consecutive addresses, then issues one transfer command. Optional macro: RTC_TIMER_CMD_EN.
// The completion pulse port is named final_out because "final" is a reserved word.
module rtc_write_seq #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter int                MAX_BURST = 4,
    parameter logic [ADDR_W-1:0] TIMER_LO  = 8'h41,
    parameter logic [ADDR_W-1:0] TIMER_HI  = 8'h43,
    parameter logic [DATA_W-1:0] CMD_TIMER = 8'hF2,
    parameter logic [DATA_W-1:0] CMD_CLOCK = 8'hF0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic [DATA_W-1:0]                  push_data,
    input  logic                               start,
    input  logic [ADDR_W-1:0]                  base_addr,
    input  logic                               abort,
    input  logic                               fin,
    output logic [DATA_W-1:0]                  data_out,
    output logic [ADDR_W-1:0]                  dir_out,
    output logic                               escribe,
    output logic                               activa,
    output logic                               final_out,
    output logic [$clog2(MAX_BURST+1)-1:0]     fifo_count,
    output logic                               full,
    output logic                               err
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int PTR_W = $clog2(MAX_BURST);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_XFER, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_mem [MAX_BURST];
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data_out;
    logic [ADDR_W-1:0]   r_dir_out;
    logic                r_escribe;
    logic                r_activa;
    logic                r_final;
    logic                r_full;
    logic                r_err;

    logic                w_push_acc;
    logic                w_pop;
    logic                w_flush;
    logic                w_load;
    logic                w_err_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [PTR_W-1:0]    w_rd_ptr_nxt;
    logic [PTR_W-1:0]    w_wr_ptr_nxt;
    logic [DATA_W-1:0]   w_head_nxt;
    logic [DATA_W-1:0]   w_cmd;
    logic [DATA_W-1:0]   w_data_nxt;
    logic [ADDR_W-1:0]   w_dir_nxt;
    logic                w_escribe_nxt;
    logic                w_activa_nxt;
    logic                w_final_nxt;

    // Pointers wrap explicitly so depths that are not a power of two work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_BURST - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_push_acc  = 1'b0;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_load      = 1'b0;
        w_err_nxt   = 1'b0;
        w_addr_nxt  = r_addr;
        case (r_state)
            S_IDLE: begin
                if (abort) begin
                    w_flush = 1'b1;
                end else begin
                    if (push) begin
                        if (r_full) w_err_nxt  = 1'b1;
                        else        w_push_acc = 1'b1;
                    end
                    if (start) begin
                        if (r_count != '0 || w_push_acc) begin
                            w_load      = 1'b1;
                            w_addr_nxt  = base_addr;
                            w_state_nxt = S_WRITE;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (abort) begin
                    w_flush     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_err_nxt = push;
                    if (fin) begin
                        w_pop      = 1'b1;
                        w_addr_nxt = r_addr + ADDR_W'(1);
                        if (r_count == CNT_W'(1)) w_state_nxt = S_XFER;
                    end
                end
            end
            S_XFER: begin
                if (abort) begin
                    w_flush     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_err_nxt = push;
                    if (fin) w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_flush     = abort;
                w_err_nxt   = push && !abort;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_count_nxt  = r_count + CNT_W'(w_push_acc) - CNT_W'(w_pop);
        w_rd_ptr_nxt = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
        w_wr_ptr_nxt = w_push_acc ? ptr_inc(r_wr_ptr) : r_wr_ptr;
        if (w_flush) begin
            w_count_nxt  = '0;
            w_rd_ptr_nxt = '0;
            w_wr_ptr_nxt = '0;
        end
        // An empty FIFO can only enter WRITE via a same-cycle push, which bypasses the memory.
        w_head_nxt = (r_count == '0) ? push_data : r_mem[w_rd_ptr_nxt];
    end

`ifdef RTC_TIMER_CMD_EN
    logic r_hit;
    logic w_hit_nxt;

    function automatic logic in_timer(input logic [ADDR_W-1:0] a);
        return (a >= TIMER_LO) && (a <= TIMER_HI);
    endfunction

    always_comb begin
        w_hit_nxt = r_hit;
        if (w_load)                         w_hit_nxt = 1'b0;
        else if (w_pop && in_timer(r_addr)) w_hit_nxt = 1'b1;
        w_cmd = w_hit_nxt ? CMD_TIMER : CMD_CLOCK;
    end

    always_ff @(posedge clk) begin
        if (reset) r_hit <= 1'b0;
        else       r_hit <= w_hit_nxt;
    end
`else
    logic w_unused_timer;
    assign w_unused_timer = ^{TIMER_LO, TIMER_HI, CMD_TIMER};
    assign w_cmd          = CMD_CLOCK;
`endif

    // Outputs describe the state being entered.
    always_comb begin
        w_data_nxt    = '0;
        w_dir_nxt     = '0;
        w_escribe_nxt = 1'b0;
        w_activa_nxt  = 1'b0;
        w_final_nxt   = 1'b0;
        case (w_state_nxt)
            S_WRITE: begin
                w_data_nxt    = w_head_nxt;
                w_dir_nxt     = w_addr_nxt;
                w_escribe_nxt = 1'b1;
                w_activa_nxt  = 1'b1;
            end
            S_XFER: begin
                w_data_nxt    = w_cmd;
                w_dir_nxt     = ADDR_W'(w_cmd);
                w_escribe_nxt = 1'b1;
                w_activa_nxt  = 1'b1;
            end
            S_DONE:  w_final_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_addr     <= '0;
            r_data_out <= '0;
            r_dir_out  <= '0;
            r_escribe  <= 1'b0;
            r_activa   <= 1'b0;
            r_final    <= 1'b0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_count    <= w_count_nxt;
            r_addr     <= w_addr_nxt;
            r_data_out <= w_data_nxt;
            r_dir_out  <= w_dir_nxt;
            r_escribe  <= w_escribe_nxt;
            r_activa   <= w_activa_nxt;
            r_final    <= w_final_nxt;
            r_full     <= (w_count_nxt == CNT_W'(MAX_BURST));
            r_err      <= w_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_acc) r_mem[r_wr_ptr] <= push_data;
    end

    assign data_out   = r_data_out;
    assign dir_out    = r_dir_out;
    assign escribe    = r_escribe;
    assign activa     = r_activa;
    assign final_out  = r_final;
    assign fifo_count = r_count;
    assign full       = r_full;
    assign err        = r_err;

endmodule

// File: tb/tb_rtc_write_seq.sv
// Directed bench for rtc_write_seq: a bus-driver model answers escribe with fin and a
// scoreboard of expected (address, data) accesses is built from the words pushed.
module tb_rtc_write_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       start = 1'b0;
    logic [7:0] base_addr = 8'h00;
    logic       abort = 1'b0;
    logic       fin = 1'b0;
    logic [7:0] data_out;
    logic [7:0] dir_out;
    logic       escribe;
    logic       activa;
    logic       final_out;
    logic [2:0] fifo_count;
    logic       full;
    logic       err;

    rtc_write_seq dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data),
        .start(start), .base_addr(base_addr), .abort(abort), .fin(fin),
        .data_out(data_out), .dir_out(dir_out), .escribe(escribe), .activa(activa),
        .final_out(final_out), .fifo_count(fifo_count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } acc_t;

    acc_t       exp_q[$];
    logic [7:0] data_q[$];
    int         mcount = 0;
    int         n_pass = 0;
    int         n_total = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model of the burst: consecutive addresses, then the transfer command.
    function automatic int plan(input logic [7:0] base);
        logic [7:0] a = base;
        logic [7:0] cmd = 8'hF0;
        int n = data_q.size();
`ifdef RTC_TIMER_CMD_EN
        logic hit = 1'b0;
`endif
        foreach (data_q[i]) begin
            exp_q.push_back('{a, data_q[i]});
`ifdef RTC_TIMER_CMD_EN
            if (a >= 8'h41 && a <= 8'h43) hit = 1'b1;
`endif
            a = a + 8'h01;
        end
`ifdef RTC_TIMER_CMD_EN
        if (hit) cmd = 8'hF2;
`endif
        exp_q.push_back('{cmd, cmd});
        data_q.delete();
        mcount = 0;
        return n;
    endfunction

    // Called right after a negedge; returns on the next negedge with push released.
    task automatic push_word(input logic [7:0] d);
        logic exp_err;
        push = 1'b1;
        push_data = d;
        exp_err = (mcount == 4);
        if (!exp_err) begin
            data_q.push_back(d);
            mcount++;
        end
        @(negedge clk);
        push = 1'b0;
        chk("push_err", err, exp_err);
        chk("push_count", fifo_count, mcount);
        chk("push_full", full, mcount == 4);
    endtask

    task automatic pop_check(input string tag);
        acc_t e;
        chk({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_dir"}, dir_out, e.a);
            chk({tag, "_data"}, data_out, e.d);
        end
    endtask

    // Bus-driver model: fin is returned the cycle after each new escribe.
    task automatic drain(input int cyc_in, output int cyc_out);
        int cyc = cyc_in;
        bit pending = 1'b0;
        bit got = 1'b0;
        while (!got && cyc < 300) begin
            if (fin) fin = 1'b0;
            else if (pending) begin
                fin = 1'b1;
                pending = 1'b0;
            end
            if (!fin && !pending && escribe) begin
                pop_check("access");
                pending = 1'b1;
            end
            if (final_out) got = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        fin = 1'b0;
        chk("final_seen", got, 1);
        chk("sb_empty", exp_q.size(), 0);
        cyc_out = cyc;
        @(negedge clk);
        chk("final_one_cycle", final_out, 0);
        chk("post_count", fifo_count, 0);
        chk("post_activa", activa, 0);
        chk("post_escribe", escribe, 0);
    endtask

    task automatic run_burst(input logic [7:0] base);
        int n;
        int cyc;
        n = plan(base);
        start = 1'b1;
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
        drain(1, cyc);
        chk("latency", cyc, 2 * n + 3);
    endtask

    initial begin
        int cyc;
        int n;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_data", data_out, 0);
        chk("rst_dir", dir_out, 0);
        chk("rst_escribe", escribe, 0);
        chk("rst_activa", activa, 0);
        chk("rst_final", final_out, 0);
        chk("rst_err", err, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_full", full, 0);

        // Basic two-word burst.
        push_word(8'h12);
        push_word(8'h34);
        run_burst(8'h20);

        // Burst through the timer range.
        push_word(8'hA1);
        push_word(8'hA2);
        push_word(8'hA3);
        run_burst(8'h42);

        // Address wrap.
        push_word(8'hC1);
        push_word(8'hC2);
        run_burst(8'hFF);

        // Overflow, abort-flush in IDLE, start with empty FIFO.
        push_word(8'h01);
        push_word(8'h02);
        push_word(8'h03);
        push_word(8'h04);
        push_word(8'h05);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        data_q.delete();
        mcount = 0;
        chk("idle_abort_count", fifo_count, 0);
        chk("idle_abort_full", full, 0);
        start = 1'b1;
        base_addr = 8'h10;
        @(negedge clk);
        start = 1'b0;
        chk("empty_start_err", err, 1);
        chk("empty_start_escribe", escribe, 0);
        chk("empty_start_activa", activa, 0);
        @(negedge clk);
        chk("empty_start_err_pulse", err, 0);
        chk("empty_start_escribe2", escribe, 0);

        // Abort together with fin on the second word of three.
        push_word(8'hB1);
        push_word(8'hB2);
        push_word(8'hB3);
        n = plan(8'h10);
        start = 1'b1;
        base_addr = 8'h10;
        @(negedge clk);
        start = 1'b0;
        pop_check("abort_w0");
        fin = 1'b1;
        @(negedge clk);
        fin = 1'b0;
        pop_check("abort_w1");
        abort = 1'b1;
        fin = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        fin = 1'b0;
        chk("abort_escribe", escribe, 0);
        chk("abort_activa", activa, 0);
        chk("abort_count", fifo_count, 0);
        chk("abort_final", final_out, 0);
        chk("abort_dir", dir_out, 0);
        chk("abort_data", data_out, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_final", final_out, 0);
        end
        exp_q.delete();

        // Reset while in XFER.
        push_word(8'h77);
        n = plan(8'h60);
        start = 1'b1;
        base_addr = 8'h60;
        @(negedge clk);
        start = 1'b0;
        pop_check("rstx_w0");
        fin = 1'b1;
        @(negedge clk);
        fin = 1'b0;
        pop_check("rstx_cmd");
        chk("rstx_escribe_before", escribe, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstx_escribe", escribe, 0);
        chk("rstx_activa", activa, 0);
        chk("rstx_count", fifo_count, 0);
        chk("rstx_dir", dir_out, 0);
        chk("rstx_data", data_out, 0);
        @(negedge clk);
        chk("rstx_no_final", final_out, 0);
        exp_q.delete();
        mcount = 0;

        // Push and start together on an empty FIFO.
        push = 1'b1;
        push_data = 8'h5A;
        start = 1'b1;
        base_addr = 8'h30;
        data_q.push_back(8'h5A);
        n = plan(8'h30);
        @(negedge clk);
        push = 1'b0;
        start = 1'b0;
        drain(1, cyc);
        chk("push_start_latency", cyc, 2 * n + 3);

        // Push during WRITE is rejected.
        push_word(8'hD1);
        push_word(8'hD2);
        n = plan(8'h50);
        start = 1'b1;
        base_addr = 8'h50;
        @(negedge clk);
        start = 1'b0;
        push = 1'b1;
        push_data = 8'h99;
        @(negedge clk);
        push = 1'b0;
        chk("write_push_err", err, 1);
        chk("write_push_count", fifo_count, 2);
        chk("write_push_escribe", escribe, 1);
        drain(0, cyc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
